sfq_pulse_decoder: RTL and testbench
====================================

SFQ_PULSE_DECODER -- requirements
Module: sfq_pulse_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per decoded word (2..32).
REQ-002 SHALL have parameter DEPTH, default 4, output FIFO entries (power of 2, 2..16).
REQ-003 SHALL have port clk, input, 1, sole system clock, rising-edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port sfq_data, input, 1, toggle-coded SFQ data line; each transition is one pulse.
REQ-006 SHALL have port sfq_clk, input, 1, toggle-coded SFQ clock line; each transition is one SFQ clock pulse.
REQ-007 SHALL have port out_ready, input, 1, consumer accepts a word.
REQ-008 SHALL have port out_word, output, WIDTH, decoded word at FIFO head.
REQ-009 SHALL have port out_valid, output, 1, FIFO non-empty.
REQ-010 SHALL have port overflow, output, 1, sticky: a word was dropped.
REQ-011 SHALL have port err_double, output, 1, sticky: at least two data pulses arrived in one SFQ period.

Function
REQ-012 SHALL detect a pulse on each SFQ line whenever the synchronised level differs from its previous registered value.
REQ-013 SHALL set a pending flag on a data pulse; the flag holds until the next SFQ clock pulse.
REQ-014 SHALL, on a data pulse while pending is already 1, set err_double and leave pending at 1.
REQ-015 SHALL, on an SFQ clock pulse, shift pending into the word LSB-first, clear pending, and increment the bit counter.
REQ-016 SHALL, when data and SFQ clock pulses are detected in the same clk cycle, apply the clock first, then set pending for the next period.
REQ-017 SHALL use states IDLE (counter 0), SHIFT (0 < counter < WIDTH) and PUSH; PUSH is entered on the WIDTH-th clock pulse.
REQ-018 SHALL, in PUSH, write the completed word to the FIFO in one cycle, reset the counter to 0, and return to IDLE.
REQ-019 SHALL, if the FIFO is full in PUSH, drop the word, set overflow, and return to IDLE.
REQ-020 SHALL continue detecting pulses during PUSH so that no pulse is lost.
REQ-021 SHALL assert out_valid the cycle after PUSH writes into an empty FIFO.
REQ-022 SHALL pop the FIFO on out_valid && out_ready; when full, a push and a pop in the same cycle both succeed.
REQ-023 SHALL present out_word from the FIFO head with no added latency.
REQ-024 SHALL wrap the FIFO read and write pointers modulo DEPTH and distinguish full from empty with an extra pointer bit.

Reset
REQ-025 SHALL, on rst at a clk edge, clear pending, the counter, the shift register, the FIFO pointers, out_valid, overflow and err_double, and return to IDLE.
REQ-026 SHALL, on reset, load the edge-detect history registers with the current synchronised input levels so that no spurious pulse is seen after reset.
REQ-027 SHALL abandon any partially shifted word on a mid-operation reset; out_word is 0 after reset.

Configuration
REQ-028 SHALL, with macro SFQ_DEC_SYNC_EN defined, pass sfq_data and sfq_clk through a 2-flop synchroniser; a pulse is detected 3 clk edges after the toggle is sampled.
REQ-029 SHALL, without SFQ_DEC_SYNC_EN, use one input register per line; a pulse is detected 1 clk edge after sampling, and the inputs SHALL be synchronous to clk.

Verification
REQ-030 WIDTH=8, pulse pattern per SFQ period 1,0,1,1,0,0,0,1 (LSB first), out_ready=1 -> out_word=8'h8D, out_valid high one cycle, err_double=0.
REQ-031 Two data toggles then one clock toggle, repeated 8 times -> out_word=8'hFF, err_double=1, overflow=0.
REQ-032 out_ready=0, DEPTH=4, five full words sent -> four words retained in order, overflow=1; then out_ready=1 -> four pops and out_valid falls.
REQ-033 Data and clock toggled in the same clk cycle at bit 0, then a clock only -> bit0=0, bit1=1.
REQ-034 rst asserted after 5 bits, then 8 clean bits of 8'hA5 -> out_word=8'hA5, no partial word emitted, no pulse detected in the reset cycle.
REQ-035 Run REQ-030 with and without SFQ_DEC_SYNC_EN -> identical words; out_valid arrives 2 clk cycles earlier without the macro.

Source files
------------

// File: rtl/sfq_pulse_decoder.sv
// Toggle-coded SFQ pulse decoder: rebuilds LSB-first words and queues them in a small FIFO.
// Define SFQ_DEC_SYNC_EN to add a 2-flop synchroniser behind the input registers.
module sfq_pulse_decoder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sfq_data,
  input  logic             sfq_clk,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  output logic             overflow,
  output logic             err_double
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

  logic dataIn_q, clkIn_q;
  logic dataSync, clkSync;

  always_ff @(posedge clk) begin
    dataIn_q <= sfq_data;
    clkIn_q  <= sfq_clk;
  end

`ifdef SFQ_DEC_SYNC_EN
  logic [1:0] dataMeta_q, clkMeta_q;

  always_ff @(posedge clk) begin
    dataMeta_q <= {dataMeta_q[0], dataIn_q};
    clkMeta_q  <= {clkMeta_q[0], clkIn_q};
  end

  assign dataSync = dataMeta_q[1];
  assign clkSync  = clkMeta_q[1];
`else
  assign dataSync = dataIn_q;
  assign clkSync  = clkIn_q;
`endif

  state_t          state_q;
  logic            dataPrev_q, clkPrev_q;
  logic            pending_q;
  logic [CW-1:0]   count_q;
  logic [WIDTH-1:0] shift_q;
  logic [PW:0]     wptr_q, rptr_q;
  logic            overflow_q, errDouble_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic dataPulse, clkPulse;
  logic empty, full, pop, pushOk;

  assign dataPulse = dataSync ^ dataPrev_q;
  assign clkPulse  = clkSync ^ clkPrev_q;

  // The extra pointer bit tells a full FIFO apart from an empty one.
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign pop    = !empty && out_ready;
  assign pushOk = !full || pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      dataPrev_q  <= dataSync;
      clkPrev_q   <= clkSync;
      pending_q   <= 1'b0;
      count_q     <= '0;
      shift_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      errDouble_q <= 1'b0;
      state_q     <= IDLE;
    end else begin
      dataPrev_q <= dataSync;
      clkPrev_q  <= clkSync;

      // A clock pulse closes the period first; a coincident data pulse opens the next one.
      if (clkPulse) begin
        pending_q <= dataPulse;
        shift_q   <= {pending_q, shift_q[WIDTH-1:1]};
      end else if (dataPulse) begin
        pending_q <= 1'b1;
        if (pending_q) errDouble_q <= 1'b1;
      end

      if (pop) rptr_q <= rptr_q + 1'b1;

      case (state_q)
        IDLE, SHIFT: begin
          if (clkPulse) begin
            count_q <= count_q + 1'b1;
            state_q <= (count_q == LAST_BIT) ? PUSH : SHIFT;
          end
        end
        PUSH: begin
          if (pushOk) wptr_q <= wptr_q + 1'b1;
          else        overflow_q <= 1'b1;
          // A clock pulse landing here is already bit 0 of the next word.
          count_q <= {{(CW-1){1'b0}}, clkPulse};
          state_q <= clkPulse ? SHIFT : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == PUSH && pushOk) mem[wptr_q[PW-1:0]] <= shift_q;
  end

  assign out_word   = empty ? '0 : mem[rptr_q[PW-1:0]];
  assign out_valid  = !empty;
  assign overflow   = overflow_q;
  assign err_double = errDouble_q;
endmodule

// File: tb/tb_sfq_pulse_decoder.sv
// Randomised and directed bench for sfq_pulse_decoder against an event-level word model.
module tb_sfq_pulse_decoder;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic sfqData = 1'b0, sfqClk = 1'b0, outReady = 1'b1;
  logic [WIDTH-1:0] outWord;
  logic outValid, overflow, errDouble;

  int errorCount = 0, checkCount = 0;
  int periodCount = 0, bitIdx = 0;
  logic [WIDTH-1:0] curWord = '0;
  logic expErr = 1'b0, expOvf = 1'b0;
  logic [WIDTH-1:0] expQ[$];
  logic [WIDTH-1:0] lastWord = '0;
  int popCount = 0, validCycles = 0;

  sfq_pulse_decoder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sfq_data(sfqData), .sfq_clk(sfqClk), .out_ready(outReady),
    .out_word(outWord), .out_valid(outValid), .overflow(overflow), .err_double(errDouble)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Each event toggles lines once; the model tracks data pulses per SFQ period.
  task automatic applyStimulus(input bit doData, input bit doClk, input int gap);
    @(negedge clk);
    if (doData) sfqData = ~sfqData;
    if (doClk)  sfqClk  = ~sfqClk;
    if (doClk) begin
      curWord[bitIdx] = (periodCount > 0);
      bitIdx++;
      if (bitIdx == WIDTH) begin
        if (!outReady && expQ.size() == DEPTH) expOvf = 1'b1;
        else expQ.push_back(curWord);
        bitIdx = 0;
      end
      periodCount = doData ? 1 : 0;
    end else if (doData) begin
      periodCount++;
      if (periodCount >= 2) expErr = 1'b1;
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendWord(input logic [WIDTH-1:0] word);
    for (int i = 0; i < WIDTH; i++) begin
      if (word[i]) applyStimulus(1'b1, 1'b0, 2);
      applyStimulus(1'b0, 1'b1, 2);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    periodCount = 0;
    bitIdx = 0;
    expErr = 1'b0;
    expOvf = 1'b0;
    expQ.delete();
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 300) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput(tag, 32'(expQ.size()), 32'd0);
  endtask

  // Word monitor: every accepted head word must match the model's oldest word.
  always begin
    @(negedge clk);
    #1;
    if (!rst && outValid) validCycles++;
    if (!rst && outValid && outReady) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousWord", 32'(outValid), 32'd0);
      end else begin
        lastWord = outWord;
        checkOutput("outWord", 32'(outWord), 32'(expQ.pop_front()));
        popCount++;
      end
    end
  end

  initial begin
    int startValid, startPops, r;
    logic [WIDTH-1:0] w;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("resetValid", 32'(outValid), 32'd0);
    checkOutput("resetWord", 32'(outWord), 32'd0);
    checkOutput("resetOverflow", 32'(overflow), 32'd0);
    checkOutput("resetErrDouble", 32'(errDouble), 32'd0);

    startValid = validCycles;
    sendWord(8'h8D);
    settle();
    drain("drain8D");
    checkOutput("word8D", 32'(lastWord), 32'h8D);
    checkOutput("validOneCycle", 32'(validCycles - startValid), 32'd1);
    checkOutput("err8D", 32'(errDouble), 32'd0);

    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 3);
    for (int i = 2; i < WIDTH; i++) applyStimulus(1'b0, 1'b1, 3);
    settle();
    drain("drainSameCycle");
    checkOutput("sameCycleWord", 32'(lastWord), 32'h02);
    checkOutput("sameCycleErr", 32'(errDouble), 32'd0);

    for (int i = 0; i < WIDTH; i++) begin
      applyStimulus(1'b1, 1'b0, 2);
      applyStimulus(1'b1, 1'b0, 2);
      applyStimulus(1'b0, 1'b1, 2);
    end
    settle();
    drain("drainDouble");
    checkOutput("doubleWord", 32'(lastWord), 32'hFF);
    checkOutput("doubleErr", 32'(errDouble), 32'd1);
    checkOutput("doubleOverflow", 32'(overflow), 32'd0);

    applyReset();
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      applyStimulus(r < 4 || r > 7, r >= 4, $urandom_range(1, 3));
    end
    while (bitIdx != 0) applyStimulus(1'b0, 1'b1, 2);
    settle();
    drain("drainRandom");
    checkOutput("randomErr", 32'(errDouble), 32'(expErr));
    checkOutput("randomOverflow", 32'(overflow), 32'(expOvf));

    applyReset();
    outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w = WIDTH'($urandom);
      sendWord(w);
    end
    settle();
    checkOutput("fullOverflow", 32'(overflow), 32'(expOvf));
    checkOutput("fullOverflowSet", 32'(overflow), 32'd1);
    checkOutput("fullValid", 32'(outValid), 32'd1);
    checkOutput("fullHead", 32'(outWord), 32'(expQ[0]));
    startPops = popCount;
    outReady = 1'b1;
    drain("drainFull");
    settle();
    checkOutput("fullPops", 32'(popCount - startPops), 32'd4);
    checkOutput("fullValidFalls", 32'(outValid), 32'd0);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 2);
    settle();
    applyReset();
    #1;
    checkOutput("midResetValid", 32'(outValid), 32'd0);
    checkOutput("midResetWord", 32'(outWord), 32'd0);
    checkOutput("midResetOverflow", 32'(overflow), 32'd0);
    startPops = popCount;
    sendWord(8'hA5);
    settle();
    drain("drainA5");
    checkOutput("wordA5", 32'(lastWord), 32'hA5);
    checkOutput("a5Pops", 32'(popCount - startPops), 32'd1);
    checkOutput("a5Err", 32'(errDouble), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end
endmodule
